// File: rtl/ysyx_25020037_ifu_if.sv
// Fetch-side bundle of the IFU: icache request/response, redirect, decode handoff.
// master = IFU (drives ic_addr/ic_valid/if_*), slave = icache + execute + decode side.
interface ysyx_25020037_ifu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] ic_addr;
    logic                  ic_valid;
    logic [DATA_WIDTH-1:0] ic_inst;
    logic                  ic_hit;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  id_ready;
    logic                  if_valid;
    logic [ADDR_WIDTH-1:0] if_pc;
    logic [DATA_WIDTH-1:0] if_inst;

    modport master (
        output ic_addr, ic_valid,
        input  ic_inst, ic_hit,
        input  redirect_valid, redirect_pc,
        input  id_ready,
        output if_valid, if_pc, if_inst
    );

    modport slave (
        input  ic_addr, ic_valid,
        output ic_inst, ic_hit,
        output redirect_valid, redirect_pc,
        output id_ready,
        input  if_valid, if_pc, if_inst
    );
endinterface

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: owns the PC, requests the icache, buffers {pc,inst} in a 2-entry FIFO.
// Ports: clk, rst (async active-low), io_fetch (master: ic_*, redirect_*, id_ready, if_*).
module ysyx_25020037_ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h3000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_25020037_ifu_if.master     io_fetch
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_MISS
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } if_id_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic                  r_pend_valid;
    logic [ADDR_WIDTH-1:0] r_pend_pc;
    if_id_t                r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_cnt;

    state_t                w_state_nx;
    logic [ADDR_WIDTH-1:0] w_pc_nx;
    logic                  w_pend_valid_nx;
    logic [ADDR_WIDTH-1:0] w_pend_pc_nx;
    logic                  w_ic_valid;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_if_valid;
    logic                  w_redir;
    logic                  w_hit;
    logic [ADDR_WIDTH-1:0] w_redir_pc;
    logic [ADDR_WIDTH-1:0] w_pc_inc;

    assign w_redir    = io_fetch.redirect_valid;
    assign w_hit      = io_fetch.ic_hit;
    assign w_redir_pc = io_fetch.redirect_pc & ~ADDR_WIDTH'(3);
    assign w_pc_inc   = r_pc + ADDR_WIDTH'(4);
    assign w_full     = (r_cnt == CNT_W'(FIFO_DEPTH));
    assign w_if_valid = (r_cnt != '0);
    assign w_pop      = w_if_valid & io_fetch.id_ready;

    always_comb begin
        w_state_nx      = r_state;
        w_pc_nx         = r_pc;
        w_pend_valid_nx = r_pend_valid;
        w_pend_pc_nx    = r_pend_pc;
        w_ic_valid      = 1'b0;
        w_push          = 1'b0;
        unique case (r_state)
            S_BOOT: begin
                w_state_nx = S_RUN;
                if (w_redir) w_pc_nx = w_redir_pc;
            end
            S_RUN: begin
                w_ic_valid = ~w_full;
                if (w_redir) begin
                    w_pc_nx = w_redir_pc;
                end else if (w_ic_valid && w_hit) begin
                    w_push  = 1'b1;
                    w_pc_nx = w_pc_inc;
                end else if (w_ic_valid) begin
                    w_state_nx = S_MISS;
                end
            end
            S_MISS: begin
                // pc stays frozen: the refill is indexed by ic_addr
                w_ic_valid = 1'b1;
                if (w_hit) begin
                    w_state_nx      = S_RUN;
                    w_pend_valid_nx = 1'b0;
                    if (w_redir) begin
                        w_pc_nx = w_redir_pc;
                    end else if (r_pend_valid) begin
                        w_pc_nx = r_pend_pc;
                    end else begin
                        w_push  = 1'b1;
                        w_pc_nx = w_pc_inc;
                    end
                end else if (w_redir) begin
                    w_pend_valid_nx = 1'b1;
                    w_pend_pc_nx    = w_redir_pc;
                end
            end
            default: w_state_nx = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_pc         <= w_pc_nx;
            r_pend_valid <= w_pend_valid_nx;
            r_pend_pc    <= w_pend_pc_nx;
        end
    end

    // MISS never pushes into a full FIFO: it is entered only from a RUN
    // issue (not full) and nothing is pushed while the refill is pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (w_redir) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= '{pc: r_pc, inst: io_fetch.ic_inst};
                r_wptr         <= r_wptr + PTR_W'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
            r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign io_fetch.ic_addr  = r_pc;
    assign io_fetch.ic_valid = w_ic_valid;
    assign io_fetch.if_valid = w_if_valid;
    assign io_fetch.if_pc    = r_fifo[r_rptr].pc;
    assign io_fetch.if_inst  = r_fifo[r_rptr].inst;
endmodule

// File: tb/tb_ysyx_25020037_ifu.sv
// Bench for ysyx_25020037_ifu: directed scenarios plus random hits/redirects/backpressure.
// Expected stream: sequential PCs from the last redirect target (or reset PC), inst = pc ^ KEY.
module tb_ysyx_25020037_ifu;
    localparam logic [31:0] RESET_PC = 32'h3000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ysyx_25020037_ifu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ysyx_25020037_ifu #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .io_fetch(bus)
    );

    assign bus.ic_inst = bus.ic_addr ^ KEY;

    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          hs_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] gen_pc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void topup();
        while (exp_q.size() < 8) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 32'd4;
        end
    endfunction

    function automatic void reseed(input logic [31:0] t);
        exp_q.delete();
        gen_pc = t;
        topup();
    endfunction

    // advance one clock; a redirect held across that edge restarts the stream
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rst && bus.redirect_valid) reseed(bus.redirect_pc & ~32'd3);
        bus.redirect_valid = 1'b0;
        topup();
    endtask

    task automatic redirect(input logic [31:0] t);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = t;
    endtask

    task automatic reset_cycle();
        cyc();
        #2 rst = 1'b0;
        repeat (2) cyc();
        #2 rst = 1'b1;
        reseed(RESET_PC);
    endtask

    // monitor: pops the scoreboard on every decode handshake, watches misses and flushes
    logic        in_miss    = 1'b0;
    logic        prev_redir = 1'b0;
    logic [31:0] miss_addr  = '0;
    logic [31:0] e;

    always @(negedge clk) begin
        if (!rst) begin
            in_miss    = 1'b0;
            prev_redir = 1'b0;
        end else begin
            if (prev_redir) chk("flush_if_valid", 32'(bus.if_valid), 32'd0);
            if (in_miss) begin
                chk("miss_ic_valid", 32'(bus.ic_valid), 32'd1);
                chk("miss_ic_addr", bus.ic_addr, miss_addr);
            end
            if (bus.if_valid && bus.id_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: got pc %h expected none", bus.if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("if_pc", bus.if_pc, e);
                    chk("if_inst", bus.if_inst, e ^ KEY);
                end
            end
            if (in_miss && bus.ic_hit) begin
                in_miss = 1'b0;
            end else if (!in_miss && bus.ic_valid && !bus.ic_hit && !bus.redirect_valid) begin
                in_miss   = 1'b1;
                miss_addr = bus.ic_addr;
            end
            prev_redir = bus.redirect_valid;
        end
    end

    task automatic rand_inputs();
        logic [31:0] t;
        bus.ic_hit   = ($urandom_range(0, 99) < 60);
        bus.id_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 2))
                0:       t = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
                1:       t = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
                default: t = $urandom;
            endcase
            redirect(t);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int k;
        bus.ic_hit         = 1'b1;
        bus.id_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        gen_pc             = RESET_PC;
        #23;
        chk("rst_ic_valid", 32'(bus.ic_valid), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_ic_addr", bus.ic_addr, RESET_PC);
        chk("rst_if_pc", bus.if_pc, 32'd0);
        chk("rst_if_inst", bus.if_inst, 32'd0);

        // startup and streaming
        cyc();
        #2 rst = 1'b1;
        reseed(RESET_PC);
        chk("boot_ic_valid", 32'(bus.ic_valid), 32'd0);
        cyc();
        chk("run_ic_valid", 32'(bus.ic_valid), 32'd1);
        hs0 = hs_cnt;
        repeat (3) cyc();
        chk("throughput", 32'(hs_cnt - hs0), 32'd2);

        // long miss at 3000_0010
        k = 0;
        while (bus.ic_addr != 32'h3000_0010 && k < 20) begin
            cyc();
            k++;
        end
        chk("reach_0010", bus.ic_addr, 32'h3000_0010);
        bus.ic_hit = 1'b0;
        repeat (8) cyc();
        chk("miss8_addr", bus.ic_addr, 32'h3000_0010);
        chk("miss8_valid", 32'(bus.ic_valid), 32'd1);
        bus.ic_hit = 1'b1;
        cyc();
        chk("after_miss_addr", bus.ic_addr, 32'h3000_0014);

        // backpressure from reset
        bus.id_ready = 1'b0;
        reset_cycle();
        repeat (4) cyc();
        chk("bp_ic_valid", 32'(bus.ic_valid), 32'd0);
        chk("bp_ic_addr", bus.ic_addr, 32'h3000_0008);
        chk("bp_if_valid", 32'(bus.if_valid), 32'd1);
        chk("bp_if_pc", bus.if_pc, 32'h3000_0000);
        bus.id_ready = 1'b1;

        // two redirects during a miss at 3000_0020
        k = 0;
        while (bus.ic_addr != 32'h3000_0020 && k < 40) begin
            cyc();
            k++;
        end
        chk("reach_0020", bus.ic_addr, 32'h3000_0020);
        bus.ic_hit = 1'b0;
        repeat (3) cyc();
        redirect(32'hA000_0100);
        cyc();
        repeat (2) cyc();
        redirect(32'hA000_0200);
        cyc();
        cyc();
        chk("pend_ic_addr", bus.ic_addr, 32'h3000_0020);
        chk("pend_ic_valid", 32'(bus.ic_valid), 32'd1);
        bus.ic_hit = 1'b1;
        cyc();
        chk("pend_target", bus.ic_addr, 32'hA000_0200);
        repeat (6) cyc();

        // redirect with full FIFO and a same-cycle pop
        bus.id_ready = 1'b0;
        repeat (4) cyc();
        chk("full_ic_valid", 32'(bus.ic_valid), 32'd0);
        bus.id_ready = 1'b1;
        redirect(32'hB000_0002);
        cyc();
        chk("redir_if_valid", 32'(bus.if_valid), 32'd0);
        chk("redir_ic_addr", bus.ic_addr, 32'hB000_0000);

        // wrap, then async reset in the middle of a miss
        redirect(32'hFFFF_FFF8);
        repeat (3) cyc();
        chk("wrap_ic_addr", bus.ic_addr, 32'h0000_0000);
        bus.ic_hit = 1'b0;
        repeat (3) cyc();
        #2 rst = 1'b0;
        #1;
        chk("arst_ic_valid", 32'(bus.ic_valid), 32'd0);
        chk("arst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("arst_ic_addr", bus.ic_addr, RESET_PC);
        repeat (2) cyc();
        #2 rst = 1'b1;
        reseed(RESET_PC);

        // random phase
        hs0 = hs_cnt;
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cyc();
        end
        chk("liveness", 32'((hs_cnt - hs0) >= 300), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
